mp_add_sequencer: RTL
=====================

// Module: mp_add_sequencer
// PURPOSE
//  Multi-precision add controller: adds two W-word operands (W <= MAXW) with one N-bit
//  word adder, one word per cycle, least-significant word first. Carry chains via an
//  internal register. Operand words come in on a valid/ready stream; sum words go out on
//  a valid/ready stream. Sits between a host/DMA word stream and result storage, so one
//  narrow adder serves arbitrarily wide additions.
// PARAMETERS
//  N     4                    word width in bits (width of the word adder)
//  MAXW  16                   maximum words per operation
//  CW    $clog2(MAXW+1)       width of num_words and the remaining-word counter
// PORTS
//  clk         in   1    single clock; all state updates on its rising edge
//  rst_n       in   1    asynchronous, active-low reset
//  start       in   1    1-cycle pulse: begin an operation
//  num_words   in   CW   word count for this operation; sampled with start; legal 1..MAXW
//  cin_init    in   1    carry-in for the least-significant word; sampled with start
//  busy        out  1    1 from accepted start until done
//  in_valid    in   1    a_word/b_word valid
//  in_ready    out  1    sequencer accepts an operand pair this cycle
//  a_word      in   N    operand A word
//  b_word      in   N    operand B word
//  out_valid   out  1    sum_word valid
//  out_ready   in   1    consumer takes sum_word this cycle
//  sum_word    out  N    sum word, same order as the inputs
//  out_last    out  1    qualifies sum_word as the final word of the operation
//  done        out  1    1-cycle pulse when the operation completes
//  cout_final  out  1    final carry-out; valid from done, held until the next accepted start
//  err         out  1    1-cycle pulse when a start is rejected
// BEHAVIOUR
//  - Reset (async assert, sync deassert at clk): state IDLE; carry, counter and all outputs 0.
//    Reset mid-operation aborts it: no done, and all partial data is discarded.
//  - States: IDLE -> RUN -> DRAIN -> IDLE.
//  - IDLE: start with 1<=num_words<=MAXW latches rem=num_words and carry=cin_init.
//    busy=1 next cycle; state goes to RUN. start with num_words==0 or >MAXW: err=1 for one
//    cycle, state stays IDLE, busy stays 0.
//  - start while busy: ignored, err=1 for one cycle, the running operation is unaffected.
//  - RUN: in_ready = !out_valid || out_ready (single output register, no bubble).
//    An input is accepted when in_valid && in_ready. On accept:
//    {c,s} = a_word + b_word + carry, computed at N+1 bits with no truncation of c.
//    Then sum_word<=s, out_valid<=1, carry<=c, rem<=rem-1, out_last<=(rem==1).
//    If rem==1, state goes to DRAIN.
//  - Latency: 1 cycle from input accept to out_valid. Throughput: 1 word/cycle while
//    out_ready=1.
//  - Output hold: while out_valid && !out_ready, sum_word and out_last hold stable and
//    in_ready=0.
//  - Output pop with no new accept: out_valid<=0 and out_last<=0.
//  - Pop and accept in the same cycle is legal; the new word replaces the popped one.
//  - DRAIN: in_ready=0. When out_valid && out_ready && out_last, the next cycle gives
//    done=1 (one cycle), cout_final<=carry, busy<=0, and state IDLE.
//  - A start is accepted in the cycle done is high (state already IDLE). Back-to-back
//    operations are legal.
//  - in_ready=0 in IDLE and DRAIN. Inputs offered then are not consumed.
//  - The rem counter never wraps: it is only decremented in RUN, where rem>=1.
// STRUCTURE
//  - Shared package mp_add_pkg: state encoding localparams (S_IDLE, S_RUN, S_DRAIN) and
//    default N/MAXW constants.
//  - One sub-module, mp_word_adder: combinational N-bit a+b+cin -> {cout,sum}.
//    Everything else (FSM, carry register, counter, output register) lives in this module.
// TESTING (N=4, MAXW=16)
//  - T1: num_words=1, cin_init=0, a=F, b=1, out_ready=1
//    -> sum_word=0 with out_last=1 one cycle after accept; done next cycle; cout_final=1.
//  - T2: num_words=3, cin_init=0, a=F,F,F, b=1,0,0 (LS first)
//    -> sums 0,0,0 and cout_final=1 (0xFFF+0x001=0x1000); continuous in_valid gives
//    in_ready=1 every RUN cycle.
//  - T3: 0x123+0x456, out_ready=0 for 3 cycles after the first sum
//    -> in_ready=0 and sum_word held at 9 during the stall; final sums 9,7,5; cout_final=0.
//  - T4: start with num_words=0, then 17 -> err pulse each time, busy=0.
//    start during RUN -> err pulse, the ongoing result is unchanged.
//  - T5: rst_n low after word 2 of 4 -> all outputs 0 at once, no done. Then
//    num_words=1, cin_init=1, a=5, b=A -> sum 0, cout_final=1.
//  - T6: start asserted in the done cycle -> accepted, busy=1 next cycle, the second
//    operation's results are correct.

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared types and defaults for the multi-precision add sequencer.
package mp_add_pkg;

    localparam int N_DEF    = 4;
    localparam int MAXW_DEF = 16;
    localparam int CW_DEF   = $clog2(MAXW_DEF + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mp_add_sequencer_if.sv
// Control, operand stream and result stream of the add sequencer.
interface mp_add_sequencer_if
    import mp_add_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
);
    logic          start;
    logic [CW-1:0] num_words;
    logic          cin_init;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a_word;
    logic [N-1:0]  b_word;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  sum_word;
    logic          out_last;
    logic          done;
    logic          cout_final;
    logic          err;

    modport master (
        output start, num_words, cin_init,
        output in_valid, a_word, b_word, out_ready,
        input  busy, in_ready, out_valid, sum_word,
        input  out_last, done, cout_final, err
    );

    modport slave (
        input  start, num_words, cin_init,
        input  in_valid, a_word, b_word, out_ready,
        output busy, in_ready, out_valid, sum_word,
        output out_last, done, cout_final, err
    );

endinterface

// File: rtl/mp_word_adder.sv
// Combinational N-bit word adder with carry in and carry out.
module mp_word_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + (N+1)'(cin);

endmodule

// File: rtl/mp_add_sequencer.sv
// Word-serial multi-precision adder: LS word first, carry kept between words.
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int MAXW = MAXW_DEF,
    parameter int CW   = $clog2(MAXW + 1)
) (
    input logic              clk,
    input logic              rst_n,
    mp_add_sequencer_if.slave bus
);

    state_t        state_q, state_d;
    logic          carry_q;
    logic [CW-1:0] rem_q;
    logic [N-1:0]  sum_q;
    logic          valid_q;
    logic          last_q;
    logic          busy_q;
    logic          done_q;
    logic          cout_q;
    logic          err_q;

    logic          in_ready_c;
    logic          acc;
    logic          pop;
    logic          fin;
    logic          range_ok;
    logic          start_ok;
    logic          start_bad;
    logic          last_in;
    logic [N-1:0]  sum_c;
    logic          cout_c;

    mp_word_adder #(.N(N)) u_add (
        .a    (bus.a_word),
        .b    (bus.b_word),
        .cin  (carry_q),
        .sum  (sum_c),
        .cout (cout_c)
    );

    assign range_ok  = (bus.num_words != '0) &&
                       (bus.num_words <= CW'(MAXW));
    assign start_ok  = bus.start && (state_q == S_IDLE) && range_ok;
    assign start_bad = bus.start && !start_ok;
    assign acc       = bus.in_valid && in_ready_c;
    assign pop       = valid_q && bus.out_ready;
    assign fin       = (state_q == S_DRAIN) && pop && last_q;
    assign last_in   = (rem_q == CW'(1));

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_RUN;
            end
            S_RUN: begin
                in_ready_c = !valid_q || bus.out_ready;
                if (acc && last_in) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (fin) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            rem_q   <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= fin;
            err_q  <= start_bad;
            if (start_ok) begin
                carry_q <= bus.cin_init;
                rem_q   <= bus.num_words;
                busy_q  <= 1'b1;
            end
            // the new word overwrites a word popped in the same cycle
            if (acc) begin
                sum_q   <= sum_c;
                valid_q <= 1'b1;
                last_q  <= last_in;
                carry_q <= cout_c;
                rem_q   <= rem_q - CW'(1);
            end else if (pop) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
            if (fin) begin
                cout_q <= carry_q;
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = valid_q;
    assign bus.sum_word   = sum_q;
    assign bus.out_last   = last_q;
    assign bus.done       = done_q;
    assign bus.cout_final = cout_q;
    assign bus.err        = err_q;

endmodule
